// File: rtl/data_sync_if.sv
// data_sync_if: bus-side signal bundle for the data_sync enable/bus synchronizer.
//   UNSYNC_BUS   - source-domain data word, stable while BUS_EN is high
//   BUS_EN       - source-domain level qualifier, asynchronous to CLK
//   SYNC_BUS     - destination-domain captured copy of UNSYNC_BUS
//   ENABLE_PULSE - one-CLK strobe marking a new SYNC_BUS value
// master: the source/observer side; slave: the synchronizer itself.
interface data_sync_if #(
   parameter int BUS_WIDTH = 8
);
   logic [BUS_WIDTH-1:0] UNSYNC_BUS;
   logic                 BUS_EN;
   logic [BUS_WIDTH-1:0] SYNC_BUS;
   logic                 ENABLE_PULSE;

   modport master (
      output UNSYNC_BUS,
      output BUS_EN,
      input  SYNC_BUS,
      input  ENABLE_PULSE
   );

   modport slave (
      input  UNSYNC_BUS,
      input  BUS_EN,
      output SYNC_BUS,
      output ENABLE_PULSE
   );
endinterface

// File: rtl/data_sync.sv
// data_sync: moves a multi-bit bus into the CLK domain using only a synchronized
// enable. BUS_EN runs through a NUM_STAGES flop chain; a rising edge of the
// synchronized enable loads SYNC_BUS from UNSYNC_BUS and raises ENABLE_PULSE for
// one cycle. The bus itself never enters a synchronizer flop; the source holds it
// stable while BUS_EN is high, so it is settled by the time the capture happens.
// Ports:
//   CLK - destination clock, all state on rising edge
//   RST - asynchronous active-low reset, clears all state
//   bus - data_sync_if slave modport (UNSYNC_BUS, BUS_EN in; SYNC_BUS,
//         ENABLE_PULSE out)
module data_sync #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic         CLK,
   input  logic         RST,
   data_sync_if.slave   bus
);

   logic [NUM_STAGES-1:0] sync_q, sync_d;
   logic                  en_prev_q, en_prev_d;
   logic [BUS_WIDTH-1:0]  sync_bus_q, sync_bus_d;
   logic                  enable_pulse_q, enable_pulse_d;
   logic                  en_sync;
   logic                  pulse_c;

   assign en_sync = sync_q[NUM_STAGES-1];
   // Rising edge of the synchronized enable; only this edge may capture the bus.
   assign pulse_c = en_sync & ~en_prev_q;

   always_comb begin
      sync_d         = {sync_q[NUM_STAGES-2:0], bus.BUS_EN};
      en_prev_d      = en_sync;
      sync_bus_d     = sync_bus_q;
      enable_pulse_d = pulse_c;
      if (pulse_c) begin
         sync_bus_d = bus.UNSYNC_BUS;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q         <= '0;
         en_prev_q      <= 1'b0;
         sync_bus_q     <= '0;
         enable_pulse_q <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         en_prev_q      <= en_prev_d;
         sync_bus_q     <= sync_bus_d;
         enable_pulse_q <= enable_pulse_d;
      end
   end

   assign bus.SYNC_BUS     = sync_bus_q;
   assign bus.ENABLE_PULSE = enable_pulse_q;

endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: directed bench for data_sync. One instance with a 2-stage chain
// driven from a per-cycle vector table, one with a 3-stage chain for the deeper
// latency; hand-written sequences cover resets during and before transfers.
module tb_data_sync;

   logic clk;
   logic rst;

   data_sync_if #(.BUS_WIDTH(8)) if2 ();
   data_sync_if #(.BUS_WIDTH(8)) if3 ();

   data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
      .CLK (clk),
      .RST (rst),
      .bus (if2.slave)
   );

   data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
      .CLK (clk),
      .RST (rst),
      .bus (if3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [7:0] bus;
      logic [7:0] exp_sync;
      logic       exp_pulse;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void add(input logic en, input logic [7:0] b,
                               input logic [7:0] s, input logic p);
      vec_t v;
      v.en = en; v.bus = b; v.exp_sync = s; v.exp_pulse = p;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk2(input string nm, input logic [7:0] es, input logic ep);
      n_checks++;
      if (if2.SYNC_BUS !== es) begin
         n_fail++;
         $display("FAIL %s ns2 SYNC_BUS: got %02h expected %02h", nm, if2.SYNC_BUS, es);
      end
      n_checks++;
      if (if2.ENABLE_PULSE !== ep) begin
         n_fail++;
         $display("FAIL %s ns2 ENABLE_PULSE: got %0b expected %0b", nm, if2.ENABLE_PULSE, ep);
      end
   endtask

   task automatic chk3(input string nm, input logic [7:0] es, input logic ep);
      n_checks++;
      if (if3.SYNC_BUS !== es) begin
         n_fail++;
         $display("FAIL %s ns3 SYNC_BUS: got %02h expected %02h", nm, if3.SYNC_BUS, es);
      end
      n_checks++;
      if (if3.ENABLE_PULSE !== ep) begin
         n_fail++;
         $display("FAIL %s ns3 ENABLE_PULSE: got %0b expected %0b", nm, if3.ENABLE_PULSE, ep);
      end
   endtask

   initial begin
      // Per-cycle vectors for the 2-stage instance; inputs apply before an edge,
      // expectations hold just after it. Capture lands two edges after the first
      // edge that sees BUS_EN high.
      add(1'b0, 8'h5A, 8'h00, 1'b0);               // bus activity while idle
      add(1'b0, 8'hC3, 8'h00, 1'b0);
      add(1'b1, 8'hA5, 8'h00, 1'b0);               // E0
      add(1'b1, 8'hA5, 8'h00, 1'b0);               // E0+1
      add(1'b1, 8'hA5, 8'hA5, 1'b1);               // E0+2 strobe
      for (int i = 0; i < 17; i++)                 // long enable, bus changes
         add(1'b1, 8'h3C, 8'hA5, 1'b0);
      for (int i = 0; i < 4; i++)
         add(1'b0, 8'hC3, 8'hA5, 1'b0);
      add(1'b1, 8'h11, 8'hA5, 1'b0);               // first back-to-back word
      add(1'b1, 8'h11, 8'hA5, 1'b0);
      add(1'b1, 8'h11, 8'h11, 1'b1);
      add(1'b1, 8'h11, 8'h11, 1'b0);
      for (int i = 0; i < 3; i++)                  // minimum low gap
         add(1'b0, 8'h22, 8'h11, 1'b0);
      add(1'b1, 8'h22, 8'h11, 1'b0);               // second word
      add(1'b1, 8'h22, 8'h11, 1'b0);
      add(1'b1, 8'h22, 8'h22, 1'b1);
      add(1'b1, 8'h22, 8'h22, 1'b0);
      for (int i = 0; i < 4; i++)
         add(1'b0, 8'h99, 8'h22, 1'b0);

      // Reset state
      rst = 1'b0;
      if2.BUS_EN = 1'b0; if2.UNSYNC_BUS = 8'hAA;
      if3.BUS_EN = 1'b0; if3.UNSYNC_BUS = 8'hAA;
      #2;
      chk2("reset", 8'h00, 1'b0);
      chk3("reset", 8'h00, 1'b0);
      tick();
      chk2("reset_edge", 8'h00, 1'b0);
      chk3("reset_edge", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Table
      foreach (vecs[i]) begin
         if2.BUS_EN     = vecs[i].en;
         if2.UNSYNC_BUS = vecs[i].bus;
         tick();
         chk2($sformatf("vec[%0d]", i), vecs[i].exp_sync, vecs[i].exp_pulse);
      end
      chk3("ns3_idle", 8'h00, 1'b0);

      // Reset in the middle of a 0xFF transfer
      if2.BUS_EN = 1'b1; if2.UNSYNC_BUS = 8'hFF;
      tick(); chk2("midrst_e0", 8'h22, 1'b0);
      tick(); chk2("midrst_e1", 8'h22, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      chk2("midrst_async", 8'h00, 1'b0);
      tick(); chk2("midrst_held", 8'h00, 1'b0);
      if2.BUS_EN = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); chk2($sformatf("midrst_idle%0d", i), 8'h00, 1'b0);
      end
      if2.BUS_EN = 1'b1;
      tick(); chk2("midrst_re_e0", 8'h00, 1'b0);
      tick(); chk2("midrst_re_e1", 8'h00, 1'b0);
      tick(); chk2("midrst_re_e2", 8'hFF, 1'b1);
      tick(); chk2("midrst_re_e3", 8'hFF, 1'b0);
      if2.BUS_EN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk2($sformatf("midrst_low%0d", i), 8'hFF, 1'b0);
      end

      // Three-stage chain
      if3.BUS_EN = 1'b1; if3.UNSYNC_BUS = 8'h5A;
      tick(); chk3("ns3_e0", 8'h00, 1'b0);
      tick(); chk3("ns3_e1", 8'h00, 1'b0);
      tick(); chk3("ns3_e2", 8'h00, 1'b0);
      tick(); chk3("ns3_e3", 8'h5A, 1'b1);
      tick(); chk3("ns3_e4", 8'h5A, 1'b0);
      if3.BUS_EN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk3($sformatf("ns3_low%0d", i), 8'h5A, 1'b0);
      end

      // Release reset with BUS_EN already high
      rst = 1'b0;
      if2.BUS_EN = 1'b1; if2.UNSYNC_BUS = 8'h77;
      if3.BUS_EN = 1'b1; if3.UNSYNC_BUS = 8'h77;
      #1;
      chk2("relhi_rst", 8'h00, 1'b0);
      chk3("relhi_rst", 8'h00, 1'b0);
      tick();
      chk2("relhi_held", 8'h00, 1'b0);
      chk3("relhi_held", 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick(); chk2("relhi_e0", 8'h00, 1'b0); chk3("relhi_e0", 8'h00, 1'b0);
      tick(); chk2("relhi_e1", 8'h00, 1'b0); chk3("relhi_e1", 8'h00, 1'b0);
      tick(); chk2("relhi_e2", 8'h77, 1'b1); chk3("relhi_e2", 8'h00, 1'b0);
      tick(); chk2("relhi_e3", 8'h77, 1'b0); chk3("relhi_e3", 8'h77, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk2($sformatf("relhi_hold%0d", i), 8'h77, 1'b0);
         chk3($sformatf("relhi_hold%0d", i), 8'h77, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_sync.md
DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 2: number of flops in the enable synchronizer chain; legal values are 2 or greater.
REQ-002 SHALL provide parameter BUS_WIDTH, default 8: width of the data bus being transferred.
REQ-003 SHALL provide port CLK, input, 1 bit: destination-domain clock; all state is updated on its rising edge.
REQ-004 SHALL provide port RST, input, 1 bit: asynchronous, active-low reset; one clock only, reset is asynchronous and active-low.
REQ-005 SHALL provide port UNSYNC_BUS, input, BUS_WIDTH bits: source-domain data, held stable by the source while BUS_EN is high.
REQ-006 SHALL provide port BUS_EN, input, 1 bit: source-domain level qualifier, asynchronous to CLK.
REQ-007 SHALL provide port SYNC_BUS, output, BUS_WIDTH bits: registered, captured copy of UNSYNC_BUS.
REQ-008 SHALL provide port ENABLE_PULSE, output, 1 bit: registered, one-CLK-cycle strobe marking a new SYNC_BUS value.

Function
REQ-009 SHALL pass BUS_EN through a shift chain of NUM_STAGES flops; the chain output is en_sync, and UNSYNC_BUS never enters any synchronizer flop.
REQ-010 SHALL register en_sync into a pulse-generation flop, en_prev, every cycle.
REQ-011 SHALL form the combinational signal pulse_c = en_sync AND NOT en_prev.
REQ-012 SHALL load SYNC_BUS from UNSYNC_BUS on the edge where pulse_c is 1, and hold SYNC_BUS on every other edge.
REQ-013 SHALL register pulse_c into ENABLE_PULSE every edge, so ENABLE_PULSE rises on the same edge as the SYNC_BUS update.
REQ-014 SHALL update SYNC_BUS and raise ENABLE_PULSE at edge E0+NUM_STAGES, where E0 is the first rising edge that samples BUS_EN high; this gives a latency of exactly NUM_STAGES edges.
REQ-015 SHALL keep ENABLE_PULSE high for exactly one CLK cycle per BUS_EN low-to-high transition, regardless of how long BUS_EN stays high.
REQ-016 SHALL produce a second strobe only after BUS_EN has been sampled low for at least one edge and then high again; the second strobe follows the same latency as REQ-014.
REQ-017 SHALL produce no strobe and no SYNC_BUS change when BUS_EN is held permanently low or permanently high after the first strobe.
REQ-018 SHALL not depend on UNSYNC_BUS except on the capture edge; bus activity while BUS_EN is low or while holding SYNC_BUS SHALL have no effect.
REQ-019 SHALL implement no buffering or overrun detection: the source guarantees BUS_EN low time and high time of at least NUM_STAGES+1 CLK periods each.

Reset
REQ-020 SHALL, while RST is low, asynchronously clear the entire synchronizer chain, en_prev, SYNC_BUS (to all zeros) and ENABLE_PULSE (to 0).
REQ-021 SHALL, when RST asserts mid-transfer (chain partially loaded or ENABLE_PULSE high), abort the transfer immediately with no strobe and SYNC_BUS = 0.
REQ-022 SHALL, when RST releases with BUS_EN already high, treat BUS_EN as a fresh transition and strobe at edge E0+NUM_STAGES after the first sampling edge.
REQ-023 SHALL treat asynchronous reset assertion as the only source of output changes outside rising CLK edges.

Verification
REQ-024 SHALL cover basic transfer: NUM_STAGES=2, BUS_WIDTH=8, UNSYNC_BUS=0xA5, BUS_EN raised before E0 -> at E0+2, SYNC_BUS=0xA5 and ENABLE_PULSE=1 for one cycle, then 0.
REQ-025 SHALL cover a long enable: BUS_EN held high for 20 cycles while UNSYNC_BUS changes from 0xA5 to 0x3C after the strobe -> exactly one strobe, and SYNC_BUS stays 0xA5.
REQ-026 SHALL cover back-to-back transfers: 0x11 then 0x22, with BUS_EN low for 3 cycles in between -> two strobes, and SYNC_BUS sequence 0x11, 0x22.
REQ-027 SHALL cover mid-operation reset: RST pulsed low at E0+1 of a 0xFF transfer -> no strobe, SYNC_BUS=0x00, and the next strobe only after BUS_EN is re-sampled high post-release.
REQ-028 SHALL cover the deeper-chain case: NUM_STAGES=3 with value 0x5A -> strobe and SYNC_BUS=0x5A at E0+3.
REQ-029 SHALL cover reset release with enable high: BUS_EN=1 and UNSYNC_BUS=0x77 during reset -> after release, one strobe at E0+NUM_STAGES with SYNC_BUS=0x77.
